// File: rtl/seg_scan_pkg.sv
// ------------------------------------------------------------------
// seg_scan_pkg: shared constants and types for the 7-segment scanner.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_t;

  // Active-low segments, bit6=a .. bit0=g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ------------------------------------------------------------------
// seg7_decode: BCD nibble to active-low 7-segment pattern, dash for 10-15.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ------------------------------------------------------------------
// seg_scan_ctrl: 4-digit multiplexed 7-seg scanner with frame-synchronous
// loads; optional blinking via macro SEG_SCAN_BLINK_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 62500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS*4-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   en,
  output logic [6:0]              m_disp,
  output logic                    frame_done
);

  localparam int SW = cnt_width(SCAN_DIV);
  localparam int DW = cnt_width(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  scan_state_t           state, state_nxt;
  logic [SW-1:0]         slot_cnt;
  logic [DW-1:0]         dig_idx;
  logic                  slot_end, frame_end;

  logic [NUM_DIGITS*4-1:0] stg_digits, sh_digits;
  logic [NUM_DIGITS-1:0]   stg_en, sh_en, stg_blink, sh_blink;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   hide;

  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   en_nxt;
  logic [6:0]              seg_nxt;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (dig_idx == DIG_LAST);
  // Gated by rst so a reset landing on the terminal cycle emits no pulse
  assign frame_done = frame_end && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN_BLANK;
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
      if (slot_end)
        dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DW'(1);
    end
  end

  assign cur_nibble = sh_digits[{dig_idx, 2'b00} +: 4];

  seg7_decode u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    state_nxt = state;
    en_nxt    = '1;
    seg_nxt   = SEG_BLANK;
    case (state)
      SCAN_BLANK: if (slot_cnt == BLANK_LAST) state_nxt = SCAN_SHOW;
      SCAN_SHOW: begin
        if (slot_end) state_nxt = SCAN_BLANK;
        if (sh_en[dig_idx] && !hide[dig_idx]) begin
          en_nxt[dig_idx] = 1'b0;
          seg_nxt         = cur_seg;
        end
      end
      default: state_nxt = SCAN_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= '1;
      m_disp <= SEG_BLANK;
    end else begin
      en     <= en_nxt;
      m_disp <= seg_nxt;
    end
  end

  // Shadow only changes at a frame boundary so a frame never mixes values
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_digits <= '0;
      stg_en     <= '0;
      stg_blink  <= '0;
      sh_digits  <= '0;
      sh_en      <= '0;
      sh_blink   <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_digits <= digits;
        stg_en     <= dig_en;
        stg_blink  <= blink_mask;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          sh_digits <= digits;
          sh_en     <= dig_en;
          sh_blink  <= blink_mask;
        end else if (pending) begin
          sh_digits <= stg_digits;
          sh_en     <= stg_en;
          sh_blink  <= stg_blink;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = cnt_width(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign hide = blink_on ? '0 : sh_blink;
`else
  logic unused_blink;
  assign unused_blink = ^sh_blink;
  assign hide         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ------------------------------------------------------------------
// tb_seg_scan_ctrl: directed + random stimulus against a cycle-count model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int BD    = 16;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dig_en = '0;
  logic [3:0]  blink_mask = '0;
  logic        load = 1'b0;
  logic [3:0]  en;
  logic [6:0]  m_disp;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cycles since reset plus shadow/staging contents
  int          cyc = 0;
  logic [15:0] sh_d = '0, st_d = '0;
  logic [3:0]  sh_e = '0, st_e = '0, sh_b = '0, st_b = '0;
  bit          pend = 1'b0;
  logic [3:0]  exp_en;
  logic [6:0]  exp_seg;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dig_en     (dig_en),
    .blink_mask (blink_mask),
    .load       (load),
    .en         (en),
    .m_disp     (m_disp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
  endtask

  task automatic step();
    int  pos, dg;
    bit  lit;
    @(posedge clk);
    if (rst) begin
      cyc = 0; pend = 0;
      sh_d = '0; sh_e = '0; sh_b = '0; st_d = '0; st_e = '0; st_b = '0;
      exp_en = 4'hF; exp_seg = 7'h7F;
    end else begin
      pos = cyc % FRAME;
      dg  = pos / SD;
      lit = ((pos % SD) >= BC) && sh_e[dg];
`ifdef SEG_SCAN_BLINK_EN
      if (((cyc / BD) % 2) == 1 && sh_b[dg]) lit = 0;
`endif
      exp_en  = 4'hF;
      if (lit) exp_en[dg] = 1'b0;
      exp_seg = lit ? ref_seg(sh_d[dg*4 +: 4]) : 7'h7F;
      if (load) begin st_d = digits; st_e = dig_en; st_b = blink_mask; end
      if (pos == FRAME - 1) begin
        if (load || pend) begin sh_d = st_d; sh_e = st_e; sh_b = st_b; end
        pend = 0;
      end else if (load) begin
        pend = 1;
      end
      cyc++;
    end
    #1;
    chk("en", {3'b0, en}, {3'b0, exp_en});
    chk("m_disp", m_disp, exp_seg);
    chk("frame_done", {6'b0, frame_done}, {6'b0, ((cyc % FRAME) == FRAME - 1) && !rst});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the next clock edge samples the given frame position
  task automatic run_to(input int p);
    int guard = 0;
    while ((cyc % FRAME) != p && guard < 4 * FRAME) begin
      step();
      guard++;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
    digits = d; dig_en = e; blink_mask = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    run(2);
    rst = 1'b0;

    do_load(16'h2580, 4'hF, 4'h0);
    run(2 * FRAME + 3);

    run_to(5);
    do_load(16'h1234, 4'hF, 4'h0);
    run(3);
    do_load(16'h5678, 4'hF, 4'h0);
    run(2 * FRAME);

    run_to(FRAME - 1);
    do_load(16'h9013, 4'hF, 4'h0);
    run(FRAME + 2);

    do_load(16'hFA00, 4'b0101, 4'h0);
    run(3 * FRAME);

    do_load(16'h2580, 4'hF, 4'b0001);
    run(5 * FRAME);

    run_to(2 * SD + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2 * FRAME);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        load       = 1'b1;
        digits     = 16'($urandom);
        dig_en     = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      step();
      rst  = 1'b0;
      load = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12500: clock cycles per digit slot (must be >= 2).
REQ-002 SHALL have parameter BLANK_CYC, default 16: blanking cycles at the start of each slot (must satisfy 1 <= BLANK_CYC < SCAN_DIV).
REQ-003 SHALL have parameter BLINK_DIV, default 62500000: clock cycles per blink half-period.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port digits, input, 16: four BCD nibbles; digit i is digits[4i+3:4i].
REQ-007 SHALL have port dig_en, input, 4: per-digit display enable.
REQ-008 SHALL have port blink_mask, input, 4: per-digit blink request.
REQ-009 SHALL have port load, input, 1: one-cycle strobe that captures digits, dig_en and blink_mask.
REQ-010 SHALL have port en, output, 4: active-low digit select.
REQ-011 SHALL have port m_disp, output, 7: active-low segments, bit6=a through bit0=g.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each 4-digit frame.

Function
REQ-013 Slot timing SHALL be as follows:
- Each digit slot is SCAN_DIV cycles: BLANK_CYC cycles in state SCAN_BLANK, then SCAN_DIV-BLANK_CYC cycles in state SCAN_SHOW.
- Slot order is digit 0,1,2,3, then wraps to 0.
REQ-014 In SCAN_BLANK, en SHALL be 4'b1111 and m_disp SHALL be 7'b1111111.
REQ-015 In SCAN_SHOW for digit i:
- en SHALL be all ones except en[i]=0.
- m_disp SHALL be the decoded shadow nibble.
REQ-016 Decode SHALL be 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; 10-15 SHALL decode to dash, 1111110.
REQ-017 A digit whose shadow dig_en bit is 0 SHALL keep its full slot time, with en=4'b1111 and m_disp=7'b1111111.
REQ-018 en and m_disp SHALL be registered outputs, reflecting the current scan state one cycle after it.
REQ-019 frame_done SHALL pulse high exactly on the last cycle of the digit-3 slot, once every 4*SCAN_DIV cycles.
REQ-020 On a load cycle, inputs SHALL be captured into staging registers and a pending flag SHALL be set.
REQ-021 A load while pending SHALL overwrite staging; last load wins.
REQ-022 On a frame_done cycle with pending set, staging SHALL copy to shadow and pending SHALL clear; the next frame uses the new value, so no mid-frame tearing occurs.
REQ-023 If load and frame_done coincide, the load inputs SHALL go directly to shadow and pending SHALL end cleared.
REQ-024 Counter widths SHALL be sized from the parameters, and every counter SHALL wrap to 0 at its terminal count (SCAN_DIV-1 and BLINK_DIV-1).

Reset
REQ-025 On rst high at a clock edge, all of the following SHALL hold:
- State = SCAN_BLANK, slot counter = 0, digit index = 0.
- Shadow and staging cleared (digits=0, dig_en=0, blink_mask=0); pending = 0.
- Blink phase = on; blink counter = 0.
- en=4'b1111, m_disp=7'b1111111, frame_done=0 from the following cycle.
REQ-026 A reset asserted mid-slot or mid-frame SHALL abandon the frame with no frame_done pulse, and any pending load SHALL be discarded.

Configuration
REQ-027 With macro SEG_SCAN_BLINK_EN defined:
- A blink-phase bit SHALL toggle every BLINK_DIV cycles.
- During the off phase, any digit with shadow blink_mask bit set SHALL be shown as a disabled digit (REQ-017).
REQ-028 Without SEG_SCAN_BLINK_EN:
- The blink counter and phase SHALL not exist.
- The blink_mask port SHALL remain present but be ignored.
- No digit SHALL blink.

Structure
REQ-029 Package seg_scan_pkg SHALL hold NUM_DIGITS=4, the scan state enum (SCAN_BLANK, SCAN_SHOW), the SEG_BLANK and SEG_DASH constants, and the 0-9 segment constants.
REQ-030 Combinational sub-module seg7_decode SHALL map a 4-bit nibble to 7-bit active-low segments per REQ-016.

Verification (SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=16)
REQ-031 Reset then load digits=16'h2580, dig_en=4'hF -> from the next frame, en per slot is 1111,1110,1110,1110 repeated for digits 0..3 with their en bit low; m_disp is 0000001, 0000000, 0100100, 0010010 for digits 0,1,2,3.
REQ-032 Load 16'h1234 mid-frame, then load 16'h5678 before frame_done -> the current frame still shows the old value and the next frame shows 8,7,6,5.
REQ-033 Load on the same cycle as frame_done -> the new value appears in the digit-0 slot of the very next frame.
REQ-034 dig_en=4'b0101, digits=16'hFA00 -> digits 1 and 3 stay blanked, digit 2 shows 1111110, and frame_done still occurs every 16 cycles.
REQ-035 With SEG_SCAN_BLINK_EN, blink_mask=4'b0001 -> digit 0 is blanked for 16-cycle windows alternating with 16 shown cycles; without the macro, digit 0 is never blanked.
REQ-036 Assert rst for one cycle mid digit-2 slot -> outputs are blank the next cycle, no frame_done fires, and scanning restarts at digit 0 with all digits disabled.
